// File: rtl/s2p_lanes_param.sv
// Multi-lane serial-to-parallel converter with bit-counter word framing and a
// valid/ready output. Optional lane-0 alignment search is enabled by S2P_ALIGN_EN.
module s2p_lanes_param #(
  parameter int unsigned      LANES    = 4,
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] SYNC_PAT = WIDTH'(8'hBC)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENB,
  input  logic [1:0]             MODO,
  input  logic                   DIR,
  input  logic [LANES-1:0]       S_IN,
  input  logic                   OUT_READY,
  output logic [LANES*WIDTH-1:0] OUT_DATA,
  output logic                   OUT_VALID,
  output logic                   OUT_OVF,
  output logic                   ALIGNED
);

  localparam int unsigned    CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef S2P_ALIGN_EN
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RUN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  if (SYNC_PAT == '0) begin : g_bad_sync_pat
    $error("SYNC_PAT must be nonzero");
  end

  state_t                        r_state;
  state_t                        w_state_next;
  logic [LANES-1:0][WIDTH-1:0]   r_sh;
  logic [LANES-1:0][WIDTH-1:0]   w_sh_next;
  logic [CW-1:0]                 r_cnt;
  logic [LANES*WIDTH-1:0]        r_data;
  logic                          r_valid;
  logic                          r_ovf;
  logic                          r_aligned;
  logic                          w_run_mode;
  logic                          w_clear;
  logic                          w_shift;
  logic                          w_done;
  logic                          w_xfer;

  always_comb begin
    w_run_mode = ENB && ((MODO == 2'b01) || (MODO == 2'b10));
    w_clear    = ENB && (MODO == 2'b11);
    w_shift    = w_run_mode && (r_state != S_IDLE);
    w_done     = w_shift && (r_state == S_RUN) && (r_cnt == LAST);
    w_xfer     = r_valid && OUT_READY;
    w_sh_next  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_sh_next[l] = DIR ? {r_sh[l][WIDTH-2:0], S_IN[l]}
                         : {S_IN[l], r_sh[l][WIDTH-1:1]};
    end
    w_state_next = r_state;
    if (w_clear) begin
      w_state_next = S_IDLE;
    end else if (w_run_mode) begin
      case (r_state)
`ifdef S2P_ALIGN_EN
        S_IDLE:   w_state_next = (MODO == 2'b01) ? S_RUN : S_SEARCH;
        // Match is judged on the value the shift register is about to take.
        S_SEARCH: if (w_sh_next[0] == SYNC_PAT) w_state_next = S_RUN;
`else
        S_IDLE:   w_state_next = S_RUN;
`endif
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_aligned <= (w_state_next == S_RUN);
      if (w_clear) begin
        r_sh  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sh <= w_sh_next;
        if (r_state == S_RUN) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        else                  r_cnt <= '0;
      end
      // A completed word is taken only if the output slot is empty or draining now.
      if (w_done && (!r_valid || w_xfer)) begin
        r_data  <= w_sh_next;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_clear)                                r_ovf <= 1'b0;
      else if (w_done && r_valid && !OUT_READY)   r_ovf <= 1'b1;
    end
  end

  assign OUT_DATA  = r_data;
  assign OUT_VALID = r_valid;
  assign OUT_OVF   = r_ovf;
  assign ALIGNED   = r_aligned;

endmodule

// File: tb/tb_s2p_lanes_param.sv
// Scoreboard bench for s2p_lanes_param (LANES=4, WIDTH=8); accepted words are
// checked in transfer order, scenario tasks check control outputs inline.
module tb_s2p_lanes_param;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENB = 1'b0;
  logic [1:0]  MODO = 2'b00;
  logic        DIR = 1'b0;
  logic [3:0]  S_IN = '0;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_OVF;
  logic        ALIGNED;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  s2p_lanes_param #(.LANES(4), .WIDTH(8), .SYNC_PAT(8'hBC)) dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .S_IN(S_IN),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_OVF(OUT_OVF), .ALIGNED(ALIGNED)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after posedge, so the negedge view matches the next edge.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_transfer: got word %h, required no word pending", OUT_DATA);
      end else begin
        exp_w = sb.pop_front();
        if (OUT_DATA !== exp_w) begin
          failures++;
          $display("FAIL sb_transfer: got %h required %h", OUT_DATA, exp_w);
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int unsigned first, input int unsigned n);
    for (int unsigned b = first; b < first + n; b++) begin
      for (int unsigned l = 0; l < 4; l++)
        S_IN[l] = DIR ? w[l*8 + 7 - b] : w[l*8 + b];
      tick();
    end
  endtask

  task automatic accept_one;
    ENB = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    ENB = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL rst_data: got %h required 0", OUT_DATA); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", OUT_VALID); end
    checks++; if (OUT_OVF !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b required 0", OUT_OVF); end
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL rst_aligned: got %b required 0", ALIGNED); end
    RESET = 1'b0; ENB = 1'b1; MODO = 2'b01;
    tick();
    checks++; if (ALIGNED !== 1'b1) begin failures++; $display("FAIL run_aligned: got %b required 1", ALIGNED); end
    send_bits(32'h12345678, 0, 8);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL pre_rst_valid: got %b required 1", OUT_VALID); end
    send_bits(32'hFFFFFFFF, 0, 3);
    #2 RESET = 1'b1;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL async_valid: got %b required 0", OUT_VALID); end
    checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL async_data: got %h required 0", OUT_DATA); end
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL async_aligned: got %b required 0", ALIGNED); end
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_lsb_first;
    DIR = 1'b0; ENB = 1'b1; MODO = 2'b01;
    tick();
    sb.push_back(32'hA8A7A6A5);
    send_bits(32'hA8A7A6A5, 0, 7);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL lsb_early_valid: got %b required 0", OUT_VALID); end
    send_bits(32'hA8A7A6A5, 7, 1);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL lsb_valid: got %b required 1", OUT_VALID); end
    checks++; if (OUT_DATA !== 32'hA8A7A6A5) begin failures++; $display("FAIL lsb_data: got %h required A8A7A6A5", OUT_DATA); end
    accept_one();
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL lsb_drain: got %b required 0", OUT_VALID); end
  endtask

  task automatic test_msb_first;
    DIR = 1'b1;
    sb.push_back(32'hF07E813C);
    send_bits(32'hF07E813C, 0, 8);
    checks++; if (OUT_DATA[7:0] !== 8'h3C) begin failures++; $display("FAIL msb_lane0: got %h required 3C", OUT_DATA[7:0]); end
    accept_one();
    DIR = 1'b0;
  endtask

  task automatic test_back_to_back;
    sb.push_back(32'hC3C3C3C3);
    send_bits(32'hC3C3C3C3, 0, 8);
    sb.push_back(32'h5A6B7C8D);
    send_bits(32'h5A6B7C8D, 0, 7);
    OUT_READY = 1'b1;
    send_bits(32'h5A6B7C8D, 7, 1);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b required 1", OUT_VALID); end
    checks++; if (OUT_DATA !== 32'h5A6B7C8D) begin failures++; $display("FAIL b2b_data: got %h required 5A6B7C8D", OUT_DATA); end
    checks++; if (OUT_OVF !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b required 0", OUT_OVF); end
    OUT_READY = 1'b0;
    accept_one();
  endtask

  task automatic test_backpressure;
    sb.push_back(32'h11111111);
    send_bits(32'h11111111, 0, 8);
    checks++; if (OUT_OVF !== 1'b0) begin failures++; $display("FAIL bp_ovf_early: got %b required 0", OUT_OVF); end
    send_bits(32'h22222222, 0, 8);
    checks++; if (OUT_DATA !== 32'h11111111) begin failures++; $display("FAIL bp_keep: got %h required 11111111", OUT_DATA); end
    checks++; if (OUT_OVF !== 1'b1) begin failures++; $display("FAIL bp_ovf: got %b required 1", OUT_OVF); end
    accept_one();
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b required 0", OUT_VALID); end
    checks++; if (OUT_OVF !== 1'b1) begin failures++; $display("FAIL bp_sticky: got %b required 1", OUT_OVF); end
  endtask

  task automatic test_clear_freeze;
    sb.push_back(32'h0F1E2D3C);
    send_bits(32'h0F1E2D3C, 0, 3);
    ENB = 1'b0;
    repeat (5) begin
      S_IN = 4'($urandom);
      tick();
    end
    ENB = 1'b1;
    send_bits(32'h0F1E2D3C, 3, 4);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL frz_early: got %b required 0", OUT_VALID); end
    send_bits(32'h0F1E2D3C, 7, 1);
    checks++; if (OUT_DATA !== 32'h0F1E2D3C) begin failures++; $display("FAIL frz_data: got %h required 0F1E2D3C", OUT_DATA); end
    send_bits(32'hFFFFFFFF, 0, 3);
    MODO = 2'b11;
    tick();
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL clr_idle: got %b required 0", ALIGNED); end
    checks++; if (OUT_OVF !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %b required 0", OUT_OVF); end
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL clr_valid_kept: got %b required 1", OUT_VALID); end
    accept_one();
    MODO = 2'b01;
    tick();
    sb.push_back(32'h87654321);
    send_bits(32'h87654321, 0, 7);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL clr_cnt_early: got %b required 0", OUT_VALID); end
    send_bits(32'h87654321, 7, 1);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL clr_cnt_valid: got %b required 1", OUT_VALID); end
    accept_one();
  endtask

  task automatic test_align;
    MODO = 2'b11;
    tick();
    MODO = 2'b10;
    tick();
`ifdef S2P_ALIGN_EN
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL search_aligned: got %b required 0", ALIGNED); end
    send_bits(32'h00000000, 0, 3);
    send_bits(32'h000000BC, 0, 8);
    checks++; if (ALIGNED !== 1'b1) begin failures++; $display("FAIL align_match: got %b required 1", ALIGNED); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL align_no_emit: got %b required 0", OUT_VALID); end
`else
    checks++; if (ALIGNED !== 1'b1) begin failures++; $display("FAIL modo10_run: got %b required 1", ALIGNED); end
`endif
    sb.push_back(32'h99776655);
    send_bits(32'h99776655, 0, 8);
    checks++; if (OUT_DATA[7:0] !== 8'h55) begin failures++; $display("FAIL align_word: got %h required 55", OUT_DATA[7:0]); end
    accept_one();
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_clear_freeze();
    test_align();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d pending words, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
